// File: rtl/game_pkg.sv
// Shared playfield constants and types for the movement / collision blocks.
package game_pkg;
    localparam int TILE       = 16;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int SPRITE     = 16;
    localparam int CORNER_OFF = SPRITE - 1;

    typedef enum logic [1:0] {IDLE, PROBE, RESP} mcState_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } coord_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts just above the last winner; rrLast moves only when en is high.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic               anyReq,
    output logic [IDW-1:0]     grantId
);
    logic [IDW-1:0] rrLast;
    logic [IDW-1:0] cand;

    always_ff @(posedge clk) begin
        if (!rst_n)
            rrLast <= IDW'(NUM_REQ - 1);
        else if (en && anyReq)
            rrLast <= grantId;
    end

    always_comb begin
        anyReq  = 1'b0;
        grantId = rrLast;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDW'((int'(rrLast) + off) % NUM_REQ);
            if (!anyReq && req[cand]) begin
                anyReq  = 1'b1;
                grantId = cand;
            end
        end
    end
endmodule

// File: rtl/move_check_arbiter.sv
// Shares the wall-lookup port among movers: grant, range-check, probe four sprite corners, ack the verdict.
module move_check_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SPRITE   = game_pkg::SPRITE,
    parameter int SCREEN_W = game_pkg::SCREEN_W,
    parameter int SCREEN_H = game_pkg::SCREEN_H
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*10-1:0]      req_x,
    input  logic [NUM_REQ*9-1:0]       req_y,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       resp_blocked,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       busy,
    output logic [9:0]                 map_x,
    output logic [8:0]                 map_y,
    input  logic                       map_is_wall
);
    import game_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);
    localparam int OFF = SPRITE - 1;

    mcState_t state, stateNext;
    coord_t   g;
    logic [IDW-1:0] gId, arbId;
    logic           anyReq, blk, outOfRange;
    logic [1:0]     corner;
    logic [9:0]     heldX, probeX;
    logic [8:0]     heldY, probeY;
    logic [NUM_REQ-1:0][9:0] reqXArr;
    logic [NUM_REQ-1:0][8:0] reqYArr;

    assign reqXArr = req_x;
    assign reqYArr = req_y;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (state == IDLE),
        .anyReq  (anyReq),
        .grantId (arbId)
    );

    // Widened adds so a sprite hanging off the right/bottom edge cannot wrap back in range.
    assign outOfRange = ({1'b0, reqXArr[arbId]} + 11'(OFF) >= 11'(SCREEN_W)) ||
                        ({1'b0, reqYArr[arbId]} + 10'(OFF) >= 10'(SCREEN_H));

    // corner[0] selects the right edge, corner[1] the bottom edge.
    assign probeX = g.x + (corner[0] ? 10'(OFF) : 10'd0);
    assign probeY = g.y + (corner[1] ? 9'(OFF) : 9'd0);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = outOfRange ? RESP : PROBE;
            PROBE:   if (corner == 2'd3) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            g      <= '0;
            gId    <= '0;
            blk    <= 1'b0;
            corner <= 2'd0;
            heldX  <= '0;
            heldY  <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (anyReq) begin
                    g.x    <= reqXArr[arbId];
                    g.y    <= reqYArr[arbId];
                    gId    <= arbId;
                    blk    <= outOfRange;
                    corner <= 2'd0;
                end
                PROBE: begin
                    blk    <= blk | map_is_wall;
                    corner <= corner + 2'd1;
                    heldX  <= probeX;
                    heldY  <= probeY;
                end
                default: ;
            endcase
        end
    end

    // Lookup address is live only while probing; otherwise the last probed corner is held.
    assign map_x        = (state == PROBE) ? probeX : heldX;
    assign map_y        = (state == PROBE) ? probeY : heldY;
    assign busy         = (state != IDLE);
    assign resp_id      = gId;
    assign resp_blocked = (state == RESP) && blk;

    always_comb begin
        req_ack = '0;
        if (state == RESP) req_ack[gId] = 1'b1;
    end
endmodule

// File: tb/tb_move_check_arbiter.sv
// Scoreboard bench for move_check_arbiter against a map whose only wall is tile (2,1).
module tb_move_check_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [39:0] req_x;
    logic [35:0] req_y;
    logic [3:0]  req_ack;
    logic        resp_blocked;
    logic [1:0]  resp_id;
    logic        busy;
    logic [9:0]  map_x;
    logic [8:0]  map_y;
    logic        map_is_wall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int blk;
        int cyc;
    } exp_t;
    exp_t expQ[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign map_is_wall = (map_x[9:4] == 6'd2) && (map_y[8:4] == 5'd1);

    move_check_arbiter #(.NUM_REQ(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_ack      (req_ack),
        .resp_blocked (resp_blocked),
        .resp_id      (resp_id),
        .busy         (busy),
        .map_x        (map_x),
        .map_y        (map_y),
        .map_is_wall  (map_is_wall)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic pushExp(input int id, input int blk, input int at);
        exp_t x;
        x.id = id; x.blk = blk; x.cyc = at;
        expQ.push_back(x);
    endtask

    task automatic setReq(input int id, input int x, input int y);
        req_x[id*10 +: 10] = 10'(x);
        req_y[id*9 +: 9]   = 9'(y);
    endtask

    task automatic waitAck(input int id);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ack[id] && k < 40);
        if (!req_ack[id]) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout id=%0d actual=none expected=ack", id);
        end
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_ack"},     int'(req_ack), 0);
        chk({tag, "_busy"},    int'(busy), 0);
        chk({tag, "_id"},      int'(resp_id), 0);
        chk({tag, "_blocked"}, int'(resp_blocked), 0);
        chk({tag, "_map_x"},   int'(map_x), 0);
        chk({tag, "_map_y"},   int'(map_y), 0);
    endtask

    // Monitor: every ack is matched against the oldest expected verdict.
    always @(negedge clk) begin
        if (req_ack != 4'd0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=%b expected=none", req_ack);
            end else begin
                e = expQ.pop_front();
                chk("ack_onehot", int'(req_ack), 1 << e.id);
                chk("ack_id", int'(resp_id), e.id);
                chk("ack_blocked", int'(resp_blocked), e.blk);
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_busy", int'(busy), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int ex[4];
        int ey[4];
        int m;
        ex = '{16, 31, 16, 31};
        ey = '{16, 16, 31, 31};
        rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
        repeat (3) @(negedge clk);
        chkReset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Lone in-range request, clear path, address sequence
        setReq(0, 16, 16); req_valid[0] = 1'b1; pushExp(0, 0, cyc + 5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("probe_map_x", int'(map_x), ex[c]);
            chk("probe_map_y", int'(map_y), ey[c]);
        end
        waitAck(0); req_valid[0] = 1'b0;
        @(negedge clk);

        // Corner 1 lands on the wall tile
        setReq(0, 20, 16); req_valid[0] = 1'b1; pushExp(0, 1, cyc + 5);
        waitAck(0); req_valid[0] = 1'b0;
        @(negedge clk);

        // Out of range: verdict one cycle after grant, Map port untouched
        setReq(1, 630, 100); req_valid[1] = 1'b1; pushExp(1, 1, cyc + 1);
        @(negedge clk);
        chk("oor_map_x", int'(map_x), 35);
        chk("oor_map_y", int'(map_y), 31);
        chk("oor_ack", int'(req_ack), 2);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("oor_idle_busy", int'(busy), 0);

        // All four continuously from reset: 0,1,2,3,0 six cycles apart
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        setReq(0, 16, 16); setReq(1, 20, 16); setReq(2, 0, 0); setReq(3, 624, 464);
        req_valid = 4'hF; m = cyc;
        pushExp(0, 0, m + 5);  pushExp(1, 1, m + 11); pushExp(2, 0, m + 17);
        pushExp(3, 0, m + 23); pushExp(0, 0, m + 29);
        repeat (29) @(negedge clk);
        req_valid = '0;
        @(negedge clk);

        // Req2 drops and moves mid-probe; verdict uses latched coords, then 3 beats 0
        setReq(2, 20, 16); setReq(3, 16, 16); req_valid[2] = 1'b1; req_valid[3] = 1'b1;
        m = cyc;
        pushExp(2, 1, m + 5); pushExp(3, 0, m + 11); pushExp(0, 0, m + 17);
        repeat (2) @(negedge clk);
        req_valid[2] = 1'b0; setReq(2, 16, 16);
        setReq(0, 16, 16); req_valid[0] = 1'b1;
        waitAck(3); req_valid[3] = 1'b0;
        waitAck(0); req_valid[0] = 1'b0;
        @(negedge clk);

        // Reset during corner 2 aborts without an ack; req0 wins afterwards
        setReq(1, 16, 16); req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("c2_map_y", int'(map_y), 31);
        rst_n = 1'b0;
        @(negedge clk);
        chkReset("midrst");
        rst_n = 1'b1;
        setReq(0, 16, 16); req_valid[0] = 1'b1;
        pushExp(0, 0, cyc + 5); pushExp(1, 0, cyc + 11);
        waitAck(0); req_valid[0] = 1'b0;
        waitAck(1); req_valid[1] = 1'b0;

        repeat (5) @(negedge clk);
        chk("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
